// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: FSM encoding, channel map, defaults.
package button_conditioner_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_HOLD_CYCLES     = 250000000;

  // Long-press FSM encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOLDING = 2'd1;
  localparam logic [1:0] FIRED   = 2'd2;

  // Channel positions in the debounced level vectors
  localparam int unsigned NUM_CH   = 6;
  localparam int unsigned CH_FOOD  = 0;
  localparam int unsigned CH_HEAL  = 1;
  localparam int unsigned CH_STATE = 2;
  localparam int unsigned CH_TEST  = 3;
  localparam int unsigned CH_LIGHT = 4;
  localparam int unsigned CH_ECHO  = 5;

  // Bits needed to count 0..n-1, never less than one
  function automatic int unsigned cntWidth(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer followed by a stability counter; level only moves
// after the synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles.
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic levelNext_c
);

  localparam int unsigned     CntW    = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      syncQ;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cntNext;

  // Metastability guard for the asynchronous raw level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) syncQ <= '0;
    else      syncQ <= {syncQ[0], raw};
  end

  // Count disagreement cycles; accept the new level on the last one
  always_comb begin
    cntNext     = '0;
    levelNext_c = level;
    if (syncQ[1] != level) begin
      if (cnt == CntLast) begin
        levelNext_c = syncQ[1];
        cntNext     = '0;
      end else begin
        cntNext = CntW'(cnt + 1'b1);
      end
    end
  end

  // Counter and accepted level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cntNext;
      level <= levelNext_c;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions four pushbuttons and two sensor levels: debounce every input,
// turn food/heal/state presses into single pulses and detect a long test press.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic food_btn_raw,
  input  logic heal_btn_raw,
  input  logic state_btn_raw,
  input  logic test_btn_raw,
  input  logic light_raw,
  input  logic echo_raw,
  output logic food_button,
  output logic heal_button,
  output logic state_button,
  output logic test_signal,
  output logic light_signal,
  output logic echo_signal
);

  localparam int unsigned      HoldW    = cntWidth(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  logic [NUM_CH-1:0] rawVec;
  logic [NUM_CH-1:0] levelVec;
  logic [NUM_CH-1:0] levelNextVec;
  logic [2:0]        btnPrev;
  logic [2:0]        btnPulse;
  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [HoldW-1:0]  holdCnt;
  logic [HoldW-1:0]  holdCntNext;
  logic              testPulse;
  logic              testPulseNext;
  logic              testLevelNext;
  logic              testRise;
  logic              unusedLevelNext;

  assign rawVec = {echo_raw, light_raw, test_btn_raw, state_btn_raw, heal_btn_raw, food_btn_raw};

  // One independent debounce cell per input
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gDebounce
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uCell (
      .clk         (clk),
      .rst         (rst),
      .raw         (rawVec[ch]),
      .level       (levelVec[ch]),
      .levelNext_c (levelNextVec[ch])
    );
  end

  // Only the test channel needs the look-ahead level
  assign unusedLevelNext = ^{levelNextVec[CH_ECHO:CH_LIGHT], levelNextVec[CH_STATE:CH_FOOD]};

  assign testLevelNext = levelNextVec[CH_TEST];
  assign testRise      = levelNextVec[CH_TEST] & ~levelVec[CH_TEST];

  // Rising-edge pulses for the short-press buttons, one cycle after acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnPrev  <= '0;
      btnPulse <= '0;
    end else begin
      btnPrev  <= levelVec[CH_STATE:CH_FOOD];
      btnPulse <= levelVec[CH_STATE:CH_FOOD] & ~btnPrev;
    end
  end

  // Long-press next state; a release always wins over the final hold count
  always_comb begin
    stateNext     = state;
    holdCntNext   = holdCnt;
    testPulseNext = 1'b0;
    case (state)
      IDLE: begin
        if (testRise) begin
          stateNext   = HOLDING;
          holdCntNext = '0;
        end
      end
      HOLDING: begin
        if (!testLevelNext) begin
          stateNext   = IDLE;
          holdCntNext = '0;
        end else if (holdCnt == HoldLast) begin
          stateNext     = FIRED;
          holdCntNext   = '0;
          testPulseNext = 1'b1;
        end else begin
          holdCntNext = HoldW'(holdCnt + 1'b1);
        end
      end
      FIRED: begin
        if (!testLevelNext) stateNext = IDLE;
      end
      default: begin
        stateNext   = IDLE;
        holdCntNext = '0;
      end
    endcase
  end

  // Long-press state, hold counter and test pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      holdCnt   <= '0;
      testPulse <= 1'b0;
    end else begin
      state     <= stateNext;
      holdCnt   <= holdCntNext;
      testPulse <= testPulseNext;
    end
  end

  assign food_button  = btnPulse[CH_FOOD];
  assign heal_button  = btnPulse[CH_HEAL];
  assign state_button = btnPulse[CH_STATE];
  assign test_signal  = testPulse;
  assign light_signal = levelVec[CH_LIGHT];
  assign echo_signal  = levelVec[CH_ECHO];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Loop index i is the edge number counted from the first edge sampling the new level.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int unsigned D = 4;
  localparam int unsigned H = 10;

  logic clk;
  logic rst;
  logic food_btn_raw, heal_btn_raw, state_btn_raw, test_btn_raw, light_raw, echo_raw;
  logic food_button, heal_button, state_button, test_signal, light_signal, echo_signal;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .food_btn_raw  (food_btn_raw),
    .heal_btn_raw  (heal_btn_raw),
    .state_btn_raw (state_btn_raw),
    .test_btn_raw  (test_btn_raw),
    .light_raw     (light_raw),
    .echo_raw      (echo_raw),
    .food_button   (food_button),
    .heal_button   (heal_button),
    .state_button  (state_button),
    .test_signal   (test_signal),
    .light_signal  (light_signal),
    .echo_signal   (echo_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output vector {echo, light, test, state, heal, food}
  function automatic logic [5:0] mk(input logic f, input logic h, input logic s,
                                    input logic t, input logic l, input logic e);
    return {e, l, t, s, h, f};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [5:0] expv);
    logic [5:0] obs;
    obs = {echo_signal, light_signal, test_signal, state_button, heal_button, food_button};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s edge %0d: observed %b expected %b (echo,light,test,state,heal,food)",
             tag, cyc, obs, expv);
    end
  endtask

  task automatic chkState(input string tag, input logic [1:0] expv);
    vectors++;
    assert (dut.state === expv) else begin
      miscompares++;
      $error("FAIL %s: fsm state observed %0d expected %0d", tag, dut.state, expv);
    end
  endtask

  initial begin
    rst = 1'b0;
    {food_btn_raw, heal_btn_raw, state_btn_raw, test_btn_raw, light_raw, echo_raw} = '0;

    // Reset state
    repeat (3) step();
    chk("reset", -1, 6'b0);
    chkState("reset_fsm", IDLE);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", i, 6'b0);
    end

    // Food press: pulse only after edge D+2, nothing on release
    for (int i = 0; i < 20; i++) begin
      food_btn_raw = 1'b1;
      step();
      chk("food_press", i, mk(i == 6, 0, 0, 0, 0, 0));
    end
    food_btn_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("food_release", i, 6'b0);
    end

    // Heal glitch of 3 cycles is rejected
    for (int i = 0; i < 15; i++) begin
      heal_btn_raw = (i < 3);
      step();
      chk("heal_glitch", i, 6'b0);
    end

    // State bounce 1-0-1-1...: last rise at edge 2, pulse at 2+D+2
    for (int i = 0; i < 20; i++) begin
      state_btn_raw = (i != 1);
      step();
      chk("state_bounce", i, mk(0, 0, i == 8, 0, 0, 0));
    end
    state_btn_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("state_release", i, 6'b0);
    end

    // Long press: debounced rise at edge 5, single pulse at 5+H
    for (int i = 0; i < 30; i++) begin
      test_btn_raw = 1'b1;
      step();
      chk("test_long", i, mk(0, 0, 0, i == 15, 0, 0));
      if (i == 10) chkState("test_holding", HOLDING);
    end
    chkState("test_fired", FIRED);
    test_btn_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("test_long_release", i, 6'b0);
    end
    chkState("test_back_idle", IDLE);

    // Release at edge 10: debounced fall lands on the would-be fire edge
    for (int i = 0; i < 25; i++) begin
      test_btn_raw = (i < 10);
      step();
      chk("test_short", i, 6'b0);
    end
    chkState("test_short_idle", IDLE);

    // Sensors: light from edge 0, echo from edge 2
    for (int i = 0; i < 13; i++) begin
      light_raw = 1'b1;
      echo_raw  = (i >= 2);
      step();
      chk("sensor_rise", i, mk(0, 0, 0, 0, i >= 5, i >= 7));
    end

    // Simultaneous food and state presses pulse together
    for (int i = 0; i < 10; i++) begin
      food_btn_raw  = 1'b1;
      state_btn_raw = 1'b1;
      step();
      chk("simultaneous", i, mk(i == 6, 0, i == 6, 0, 1, 1));
    end
    for (int i = 0; i < 10; i++) begin
      food_btn_raw  = 1'b0;
      state_btn_raw = 1'b0;
      light_raw     = 1'b0;
      echo_raw      = 1'b0;
      step();
      chk("release_all", i, mk(0, 0, 0, 0, i < 5, i < 5));
    end

    // Reset at edge 12 aborts the hold; held input restarts from edge 14
    for (int i = 0; i < 35; i++) begin
      test_btn_raw = 1'b1;
      light_raw    = 1'b1;
      if (i == 12) begin
        rst = 1'b0;
        #1;
        chk("async_reset", i, 6'b0);
      end
      if (i == 14) rst = 1'b1;
      step();
      chk("reset_hold", i, mk(0, 0, 0, i == 29, (i >= 5 && i < 12) || i >= 19, 0));
      if (i == 12) chkState("reset_hold_fsm", IDLE);
    end
    test_btn_raw = 1'b0;
    light_raw    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("final_release", i, mk(0, 0, 0, 0, i < 5, 0));
    end
    chkState("final_idle", IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
